// File: rtl/comp_share_arb_if.sv
// -----------------------------------------------------------------------------
// comp_share_arb_if
// Handshake bundle for the shared ones-count arbiter.
//   a_valid/a_data/a_ready : requester A word channel
//   b_valid/b_data/b_ready : requester B word channel
//   rsp_valid/rsp_ready    : result channel toward the consumer
//   rsp_id                 : 0 = result belongs to A, 1 = result belongs to B
//   rsp_count              : number of ones in the accepted word
//   busy                   : a job is in flight (RUN or DONE)
// Modports: slave = arbiter side, master = requesters/consumer side.
// -----------------------------------------------------------------------------
interface comp_share_arb_if #(
   parameter int W = 16
);
   localparam int CW = $clog2(W + 1);

   logic          a_valid;
   logic [W-1:0]  a_data;
   logic          a_ready;
   logic          b_valid;
   logic [W-1:0]  b_data;
   logic          b_ready;
   logic          rsp_valid;
   logic          rsp_ready;
   logic          rsp_id;
   logic [CW-1:0] rsp_count;
   logic          busy;

   modport slave (
      input  a_valid, a_data, b_valid, b_data, rsp_ready,
      output a_ready, b_ready, rsp_valid, rsp_id, rsp_count, busy
   );

   modport master (
      output a_valid, a_data, b_valid, b_data, rsp_ready,
      input  a_ready, b_ready, rsp_valid, rsp_id, rsp_count, busy
   );
endinterface

// File: rtl/comp_share_arb.sv
// -----------------------------------------------------------------------------
// comp_share_arb
// Two-requester round-robin arbiter that time-shares one 4-bit ones counter
// (4:3 compressor) over W-bit population-count jobs. The accepted word is
// shifted through the counter one nibble per cycle, LSB nibble first, and the
// partial counts are accumulated. One job outstanding at a time.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : comp_share_arb_if.slave (A/B word channels, result channel, busy)
// Parameters:
//   W    : word width, multiple of 4, at least 4
// -----------------------------------------------------------------------------
module comp_share_arb #(
   parameter int W = 16
) (
   input  logic            clk,
   input  logic            rst,
   comp_share_arb_if.slave bus
);
   localparam int CW    = $clog2(W + 1);
   localparam int BEATS = W / 4;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_reg;
   logic [W-1:0]  shreg_reg;
   logic [CW-1:0] acc_reg;
   logic [BW-1:0] beat_reg;
   logic          last_grant_reg;   // 0 = A won last, 1 = B won last
   logic          rsp_id_reg;
   logic [CW-1:0] rsp_count_reg;
   logic          rsp_valid_reg;
   logic          busy_reg;

   logic          a_ready_next;
   logic          b_ready_next;

   // Readies are combinational so a grant and its handshake land in the same
   // cycle; the loser of a tie is whoever was granted most recently.
   assign a_ready_next = !rst && (state_reg == IDLE) && bus.a_valid &&
                         (!bus.b_valid || last_grant_reg);
   assign b_ready_next = !rst && (state_reg == IDLE) && bus.b_valid &&
                         (!bus.a_valid || !last_grant_reg);

   // Shared 4:3 counter: a full adder on bits 0..2, then a half-adder stage
   // folds bit 3 in, giving {c4,c2,c1}.
   logic [3:0]    nib;
   logic          fa_s;
   logic          fa_c;
   logic          ha_c;
   logic [2:0]    nib_cnt;
   logic [CW-1:0] acc_next;

   assign nib      = shreg_reg[3:0];
   assign fa_s     = nib[0] ^ nib[1] ^ nib[2];
   assign fa_c     = (nib[0] & nib[1]) | (nib[0] & nib[2]) | (nib[1] & nib[2]);
   assign ha_c     = fa_s & nib[3];
   assign nib_cnt  = {fa_c & ha_c, fa_c ^ ha_c, fa_s ^ nib[3]};
   assign acc_next = acc_reg + CW'(nib_cnt);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         shreg_reg      <= '0;
         acc_reg        <= '0;
         beat_reg       <= '0;
         last_grant_reg <= 1'b1;
         rsp_id_reg     <= 1'b0;
         rsp_count_reg  <= '0;
         rsp_valid_reg  <= 1'b0;
         busy_reg       <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (a_ready_next) begin
                  shreg_reg      <= bus.a_data;
                  acc_reg        <= '0;
                  beat_reg       <= '0;
                  rsp_id_reg     <= 1'b0;
                  last_grant_reg <= 1'b0;
                  busy_reg       <= 1'b1;
                  state_reg      <= RUN;
               end else if (b_ready_next) begin
                  shreg_reg      <= bus.b_data;
                  acc_reg        <= '0;
                  beat_reg       <= '0;
                  rsp_id_reg     <= 1'b1;
                  last_grant_reg <= 1'b1;
                  busy_reg       <= 1'b1;
                  state_reg      <= RUN;
               end
            end
            RUN: begin
               acc_reg   <= acc_next;
               shreg_reg <= shreg_reg >> 4;
               beat_reg  <= beat_reg + 1'b1;
               if (beat_reg == LAST_BEAT) begin
                  rsp_count_reg <= acc_next;
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end
            end
            DONE: begin
               if (bus.rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  busy_reg      <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg     <= IDLE;
               rsp_valid_reg <= 1'b0;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.a_ready   = a_ready_next;
   assign bus.b_ready   = b_ready_next;
   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_id    = rsp_id_reg;
   assign bus.rsp_count = rsp_count_reg;
   assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_comp_share_arb.sv
// -----------------------------------------------------------------------------
// tb_comp_share_arb
// Directed bench for comp_share_arb with W=16: a vector table of single jobs
// plus hand-written sequences for round-robin, backpressure, reset mid-job and
// a lone requester streaming words.
// -----------------------------------------------------------------------------
module tb_comp_share_arb;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   chk_cnt = 0;
   int   pass_cnt = 0;
   bit   both_ready_seen = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   comp_share_arb_if #(.W(W)) bus ();

   comp_share_arb #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // readies must never overlap; sampled mid-low-phase
   always @(negedge clk) begin
      #2;
      if (bus.a_ready && bus.b_ready) both_ready_seen = 1'b1;
   end

   typedef struct {
      bit          src;        // 0 = A, 1 = B
      logic [15:0] data;
      int          exp_count;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input int act, input int exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Present a word, wait (bounded) for ready, return the cycle of the accept edge.
   task automatic send(input bit src, input logic [15:0] data, output int acc_cyc);
      bit got;
      got = 1'b0;
      acc_cyc = -1;
      if (src) begin bus.b_valid = 1'b1; bus.b_data = data; end
      else     begin bus.a_valid = 1'b1; bus.a_data = data; end
      for (int t = 0; t < 20; t++) begin
         #1;
         if ((src ? bus.b_ready : bus.a_ready) === 1'b1) begin got = 1'b1; break; end
         @(negedge clk);
      end
      if (!got) begin
         check("ready_timeout", 0, 1);
      end else begin
         @(posedge clk);
         #1;
         acc_cyc = cyc;
      end
      if (src) bus.b_valid = 1'b0;
      else     bus.a_valid = 1'b0;
   endtask

   // Wait (bounded) for rsp_valid after an accept; check latency, id, count.
   task automatic wait_rsp(input string name, input int exp_id, input int exp_count,
                           input int acc_cyc);
      bit got;
      got = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (bus.rsp_valid === 1'b1) begin got = 1'b1; break; end
         check({name, "_busy"}, int'(bus.busy), 1);
      end
      if (!got) begin
         check({name, "_rsp_timeout"}, 0, 1);
      end else begin
         check({name, "_latency"}, cyc - acc_cyc, 4);
         check({name, "_id"}, int'(bus.rsp_id), exp_id);
         check({name, "_count"}, int'(bus.rsp_count), exp_count);
         $display("job %s: id=%0d count=%0d latency=%0d", name, bus.rsp_id,
                  bus.rsp_count, cyc - acc_cyc);
      end
   endtask

   initial begin
      int  k, k1, k2, k3;
      bit  seen;
      bit  got;
      bit  got_b;

      vecs[0] = '{1'b0, 16'hFFFF, 16};
      vecs[1] = '{1'b0, 16'h0000, 0};
      vecs[2] = '{1'b0, 16'hA5A5, 8};
      vecs[3] = '{1'b0, 16'h7777, 12};
      vecs[4] = '{1'b0, 16'h8421, 4};
      vecs[5] = '{1'b1, 16'h00F0, 4};
      vecs[6] = '{1'b1, 16'h1234, 5};
      vecs[7] = '{1'b0, 16'h0F0F, 8};

      // ---------------- reset ----------------
      rst = 1'b1;
      bus.a_valid = 1'b0; bus.a_data = '0;
      bus.b_valid = 1'b0; bus.b_data = '0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.a_valid = 1'b1; bus.b_valid = 1'b1;
      #1;
      check("rst_rsp_valid", int'(bus.rsp_valid), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_count", int'(bus.rsp_count), 0);
      check("rst_id", int'(bus.rsp_id), 0);
      check("rst_a_ready", int'(bus.a_ready), 0);
      check("rst_b_ready", int'(bus.b_ready), 0);
      @(negedge clk);
      rst = 1'b0;

      // ---------------- round-robin, both held valid ----------------
      bus.a_data = 16'h0001; bus.b_data = 16'h00F0;
      for (int j = 0; j < 4; j++) begin
         got = 1'b0;
         got_b = 1'b0;
         for (int t = 0; t < 20; t++) begin
            #1;
            if (bus.a_ready === 1'b1 || bus.b_ready === 1'b1) begin
               got = 1'b1; got_b = bus.b_ready; break;
            end
            @(negedge clk);
         end
         if (!got) begin
            check("rr_ready_timeout", 0, 1);
         end else begin
            check($sformatf("rr_grant%0d", j), int'(got_b), j % 2);
            @(posedge clk);
            #1;
            k = cyc;
            wait_rsp($sformatf("rr%0d", j), j % 2, (j % 2) ? 4 : 1, k);
         end
      end
      bus.a_valid = 1'b0; bus.b_valid = 1'b0;

      // ---------------- table-driven single jobs ----------------
      @(negedge clk);
      foreach (vecs[i]) begin
         send(vecs[i].src, vecs[i].data, k);
         if (k >= 0) wait_rsp($sformatf("vec%0d", i), int'(vecs[i].src), vecs[i].exp_count, k);
         @(negedge clk);
         check($sformatf("vec%0d_rsp_drop", i), int'(bus.rsp_valid), 0);
      end

      // ---------------- backpressure ----------------
      bus.rsp_ready = 1'b0;
      send(1'b0, 16'hA5A5, k);
      wait_rsp("bp", 0, 8, k);
      bus.b_valid = 1'b1; bus.b_data = 16'h0003;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_rsp_valid", int'(bus.rsp_valid), 1);
         check("bp_id", int'(bus.rsp_id), 0);
         check("bp_count", int'(bus.rsp_count), 8);
         check("bp_a_ready", int'(bus.a_ready), 0);
         check("bp_b_ready", int'(bus.b_ready), 0);
         check("bp_busy", int'(bus.busy), 1);
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      check("bp_release_rsp_valid", int'(bus.rsp_valid), 0);
      check("bp_release_busy", int'(bus.busy), 0);
      check("bp_release_idle_b_ready", int'(bus.b_ready), 1);
      check("bp_release_count_hold", int'(bus.rsp_count), 8);
      bus.b_valid = 1'b0;
      @(negedge clk);

      // ---------------- reset mid-RUN ----------------
      send(1'b0, 16'hFFFF, k);
      @(negedge clk);               // 1st RUN cycle
      @(negedge clk);               // 2nd RUN cycle
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_rsp_valid", int'(bus.rsp_valid), 0);
      check("midrst_busy", int'(bus.busy), 0);
      @(negedge clk);
      bus.a_valid = 1'b1; bus.b_valid = 1'b1;
      #1;
      check("midrst_a_ready_in_rst", int'(bus.a_ready), 0);
      check("midrst_b_ready_in_rst", int'(bus.b_ready), 0);
      @(negedge clk);
      rst = 1'b0;
      bus.a_valid = 1'b0; bus.b_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b0) seen = 1'b1;
      end
      check("midrst_no_rsp", int'(seen), 0);
      bus.a_valid = 1'b1; bus.a_data = 16'h0001;
      bus.b_valid = 1'b1; bus.b_data = 16'h00F0;
      #1;
      check("midrst_a_first", int'(bus.a_ready), 1);
      check("midrst_b_wait", int'(bus.b_ready), 0);
      @(negedge clk);
      send(1'b0, 16'h0001, k);
      bus.b_valid = 1'b0;
      if (k >= 0) wait_rsp("midrst_after", 0, 1, k);
      @(negedge clk);

      // ---------------- lone requester B, back-to-back ----------------
      send(1'b1, 16'hFFFF, k1);
      wait_rsp("solo0", 1, 16, k1);
      send(1'b1, 16'h0003, k2);
      check("solo_spacing1", k2 - k1, 6);
      wait_rsp("solo1", 1, 2, k2);
      send(1'b1, 16'h7000, k3);
      check("solo_spacing2", k3 - k2, 6);
      wait_rsp("solo2", 1, 3, k3);
      @(negedge clk);

      check("ready_exclusive", int'(both_ready_seen), 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
